// File: rtl/lns_add_scheduler.sv
// Round-robin scheduler sharing one external combinational LNS adder among NREQ requesters.
// Optional saturating response counter enabled by defining LNS_SCHED_OPCOUNT_EN.
module lns_add_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned WBITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WBITS-1:0] req_a,
    input  logic [NREQ-1:0]       req_sa,
    input  logic [NREQ*WBITS-1:0] req_b,
    input  logic [NREQ-1:0]       req_sb,
    output logic [WBITS-1:0]      add_a,
    output logic [WBITS-1:0]      add_b,
    output logic                  add_sa,
    output logic                  add_sb,
    input  logic [WBITS-1:0]      add_result,
    input  logic                  add_rsign,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WBITS-1:0]      resp_result,
    output logic                  resp_sign
`ifdef LNS_SCHED_OPCOUNT_EN
    ,
    input  logic                  op_count_clr,
    output logic [15:0]           op_count
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WBITS-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_sa_q, add_sa_d, add_sb_q, add_sb_d;
    logic [WBITS-1:0] result_q, result_d;
    logic             sign_q, sign_d;

    logic             any_valid;
    logic [IDW-1:0]   grant;
    logic [IDW:0]     idx_w;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx_w     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (idx_w >= (IDW + 1)'(NREQ)) begin
                idx_w = idx_w - (IDW + 1)'(NREQ);
            end
            if (req_valid[idx_w[IDW-1:0]]) begin
                any_valid = 1'b1;
                grant     = idx_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_sa_d   = add_sa_q;
        add_sb_d   = add_sb_q;
        result_d   = result_q;
        sign_d     = sign_q;
        req_ready  = '0;
        resp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    add_a_d  = req_a[grant*WBITS +: WBITS];
                    add_b_d  = req_b[grant*WBITS +: WBITS];
                    add_sa_d = req_sa[grant];
                    add_sb_d = req_sb[grant];
                    id_d     = grant;
                    state_d  = StExec;
                end
            end
            StExec: begin
                result_d = add_result;
                sign_d   = add_rsign;
                state_d  = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_sa_q <= 1'b0;
            add_sb_q <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_sa_q <= add_sa_d;
            add_sb_q <= add_sb_d;
            result_q <= result_d;
            sign_q   <= sign_d;
        end
    end

    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign add_sa      = add_sa_q;
    assign add_sb      = add_sb_q;
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_sign   = sign_q;

`ifdef LNS_SCHED_OPCOUNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (op_count_clr) begin
            op_count_d = '0;
        end else if (resp_valid && resp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule
